// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// master = fetch side, slave = memory side.
interface instruction_fetch_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one imem request per phase_fetch and registers
// inst/curr_pc_fd/next_pc_fd for decode; redirects discard stale responses.
module instruction_fetch #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter logic [31:0]     NOP_INST    = 32'h0000_0013,
  parameter int unsigned     ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phase_fetch,
  input  logic             stall_decode,
  input  logic             redirect_en,
  input  logic [XLEN-1:0]  redirect_pc,
  instruction_fetch_if.master imem,
  output logic [31:0]      inst,
  output logic [XLEN-1:0]  curr_pc_fd,
  output logic [XLEN-1:0]  next_pc_fd,
  output logic             inst_valid,
  output logic             stall_fetch,
  output logic             misalign_err,
  output logic             fetch_err
);

  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t          state, state_nx;
  logic [XLEN-1:0] pc, pc_nx, pc_inc, target, addr_nx;
  logic [7:0]      cnt, cnt_nx;
  logic            ack, timeout, start, deliver, use_nop, ferr_set;

  assign target  = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_inc  = pc + XLEN'(4);
  assign ack     = imem.imem_req & imem.imem_ack;
  // >= covers a redirect taken on the last BUSY wait cycle, which lands in FLUSH one past CNT_LAST
  assign timeout = !ack && (cnt >= CNT_LAST);
  assign start   = phase_fetch && !stall_decode;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = BUSY;
      BUSY: begin
        if (ack)              state_nx = IDLE;
        else if (redirect_en) state_nx = FLUSH;
        else if (timeout)     state_nx = IDLE;
      end
      FLUSH: if (ack || timeout) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pc_nx    = pc;
    cnt_nx   = cnt;
    addr_nx  = imem.imem_addr;
    deliver  = 1'b0;
    use_nop  = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect_en) pc_nx = target;
        if (start) begin
          // a redirect arriving with the fetch strobe steers this fetch to the target
          addr_nx = redirect_en ? target : pc;
          cnt_nx  = '0;
        end
      end
      BUSY: begin
        if (ack) begin
          if (redirect_en) pc_nx = target;
          else begin
            deliver = 1'b1;
            pc_nx   = pc_inc;
          end
        end else if (redirect_en) begin
          pc_nx  = target;
          cnt_nx = cnt + 8'd1;
        end else if (timeout) begin
          deliver  = 1'b1;
          use_nop  = 1'b1;
          ferr_set = 1'b1;
          pc_nx    = pc_inc;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      FLUSH: begin
        if (redirect_en) pc_nx = target;
        if (timeout)   ferr_set = 1'b1;
        else if (!ack) cnt_nx = cnt + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC;
      cnt            <= '0;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= RESET_PC;
      stall_fetch    <= 1'b0;
      inst           <= NOP_INST;
      curr_pc_fd     <= RESET_PC;
      next_pc_fd     <= RESET_PC + XLEN'(4);
      inst_valid     <= 1'b0;
      misalign_err   <= 1'b0;
      fetch_err      <= 1'b0;
    end else begin
      pc             <= pc_nx;
      cnt            <= cnt_nx;
      imem.imem_req  <= (state_nx != IDLE);
      imem.imem_addr <= addr_nx;
      stall_fetch    <= (state_nx != IDLE);
      inst_valid     <= deliver;
      if (deliver) begin
        inst       <= use_nop ? NOP_INST : imem.imem_rdata;
        curr_pc_fd <= pc;
        next_pc_fd <= pc_inc;
      end
      if (ferr_set) fetch_err <= 1'b1;
      if (redirect_en && (redirect_pc[1:0] != 2'b00)) misalign_err <= 1'b1;
    end
  end

endmodule
